// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer between decode, the combinational ALU and writeback.
// Optional build macro: ILLEGAL_OP_TRAP_EN (adds illegal_op output; unknown opcodes return 0).

`ifndef ADD
`define ADD      14'h0001
`define ADDI     14'h0002
`define SUB      14'h0004
`define MUL      14'h0008
`define LDB      14'h0010
`define LDW      14'h0020
`define STB      14'h0040
`define STW      14'h0080
`define BEQ      14'h0100
`define MOV      14'h0200
`define JUMP     14'h0400
`define TLBWRITE 14'h0800
`define IRET     14'h1000
`endif

module alu_issue_ctrl #(
    parameter int OP_W    = 14,
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_w,
    output logic [4:0]        out_rd,
    output logic [OP_W-1:0]   out_op,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic              illegal_op,
`endif
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_valid/in_ready: decode -> this block; out_valid/out_ready: this block -> writeback.
    // out_* stay stable while out_valid is high and out_ready is low.

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        rd_q;
    logic              accept;
    logic              capture;
    logic              load_cnt;
    logic              is_mul;
    logic [DATA_W-1:0] cap_w;
`ifdef ILLEGAL_OP_TRAP_EN
    logic              cap_illegal;
`endif

    assign in_ready = rst_n & ~flush & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != IDLE);
    assign is_mul   = (alu_op == `MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_cnt = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = EXEC;
                EXEC: begin
                    if (is_mul && (MUL_LAT > 1)) begin
                        load_cnt = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: if (out_ready) state_d = accept ? EXEC : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moves and control-transfer ops bypass the ALU and return the latched x operand.
    always_comb begin
        cap_w = alu_w;
`ifdef ILLEGAL_OP_TRAP_EN
        cap_illegal = 1'b0;
`endif
        case (alu_op)
            `MOV, `JUMP, `TLBWRITE, `IRET: cap_w = alu_x;
            `ADD, `ADDI, `SUB, `MUL, `LDB, `LDW, `STB, `STW, `BEQ: cap_w = alu_w;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                cap_w       = '0;
                cap_illegal = 1'b1;
`else
                cap_w = alu_w;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op    <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_w     <= '0;
            out_rd    <= '0;
            out_op    <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else if (flush) begin
            cnt_q     <= '0;
            out_valid <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_op <= in_op;
                alu_x  <= in_x;
                alu_y  <= in_y;
                rd_q   <= in_rd;
            end
            if (load_cnt)
                cnt_q <= CNT_LOAD;
            else if ((state_q == WAIT) && (cnt_q != '0))
                cnt_q <= cnt_q - CNT_W'(1);
            if (capture) begin
                out_valid <= 1'b1;
                out_w     <= cap_w;
                out_rd    <= rd_q;
                out_op    <= alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
                illegal_op <= cap_illegal;
`endif
            end else if ((state_q == HOLD) && out_ready) begin
                out_valid <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
                illegal_op <= 1'b0;
`endif
            end
        end
    end

endmodule
